// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer: stereo pairs are queued in a small FIFO and shifted out MSB first,
// timed by a codec-supplied bit clock and frame clock that are asynchronous to clock.
module audio_dac_serializer #(
    parameter int unsigned W     = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] left_in,
    input  logic [W-1:0] right_in,
    input  logic         write,
    output logic         write_ready,
    input  logic         bclk,
    input  logic         daclrck,
    output logic         dacdat,
    output logic         underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [2:0] {
        StWaitFrame,
        StLoad,
        StSkipL,
        StLeft,
        StPadL,
        StSkipR,
        StRight,
        StPadR
    } state_e;

    state_e state_q, state_d;

    // [0],[1] form the 2-flop synchronizer; [2] is the previous synchronized value.
    logic [2:0] bclk_q, lrck_q;
    logic       bclk_fall, lrck_fall, lrck_rise;

    logic [2*W-1:0] mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic           write_ready_q, write_ready_d;
    logic           empty, full_d, push, pop;

    logic [W-1:0]  sr_l_q, sr_l_d, sr_r_q, sr_r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dacdat_q, dacdat_d;
    logic          underflow_q, underflow_d;

    assign bclk_fall = bclk_q[2] & ~bclk_q[1];
    assign lrck_fall = lrck_q[2] & ~lrck_q[1];
    assign lrck_rise = ~lrck_q[2] & lrck_q[1];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign push     = write & write_ready_q;
    assign pop      = (state_q == StLoad) & ~empty;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    assign full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    assign write_ready_d = ~full_d;

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {left_in, right_in};
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_l_d      = sr_l_q;
        sr_r_d      = sr_r_q;
        cnt_d       = cnt_q;
        underflow_d = 1'b0;
        // dacdat is only ever updated on a bit-clock falling edge; zero unless shifting.
        dacdat_d    = bclk_fall ? 1'b0 : dacdat_q;

        unique case (state_q)
            StWaitFrame: begin
                if (lrck_fall) state_d = StLoad;
            end
            StLoad: begin
                if (empty) begin
                    sr_l_d      = '0;
                    sr_r_d      = '0;
                    underflow_d = 1'b1;
                end else begin
                    {sr_l_d, sr_r_d} = mem_q[rd_ptr_q[AW-1:0]];
                end
                cnt_d   = '0;
                state_d = StSkipL;
            end
            StSkipL: begin
                if (lrck_rise) begin
                    cnt_d   = '0;
                    state_d = StSkipR;
                end else if (bclk_fall) begin
                    state_d = StLeft;
                end
            end
            StLeft: begin
                if (lrck_rise) begin
                    cnt_d   = '0;
                    state_d = StSkipR;
                end else if (bclk_fall) begin
                    if (cnt_q == CW'(W)) begin
                        state_d = StPadL;
                    end else begin
                        dacdat_d = sr_l_q[W-1];
                        sr_l_d   = {sr_l_q[W-2:0], 1'b0};
                        cnt_d    = cnt_q + CW'(1);
                    end
                end
            end
            StPadL: begin
                if (lrck_rise) begin
                    cnt_d   = '0;
                    state_d = StSkipR;
                end
            end
            StSkipR: begin
                if (lrck_fall) begin
                    state_d = StLoad;
                end else if (bclk_fall) begin
                    state_d = StRight;
                end
            end
            StRight: begin
                if (lrck_fall) begin
                    state_d = StLoad;
                end else if (bclk_fall) begin
                    if (cnt_q == CW'(W)) begin
                        state_d = StPadR;
                    end else begin
                        dacdat_d = sr_r_q[W-1];
                        sr_r_d   = {sr_r_q[W-2:0], 1'b0};
                        cnt_d    = cnt_q + CW'(1);
                    end
                end
            end
            StPadR: begin
                if (lrck_fall) state_d = StLoad;
            end
            default: state_d = StWaitFrame;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bclk_q        <= '0;
            lrck_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            write_ready_q <= 1'b0;
            state_q       <= StWaitFrame;
            sr_l_q        <= '0;
            sr_r_q        <= '0;
            cnt_q         <= '0;
            dacdat_q      <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            bclk_q        <= {bclk_q[1:0], bclk};
            lrck_q        <= {lrck_q[1:0], daclrck};
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            write_ready_q <= write_ready_d;
            state_q       <= state_d;
            sr_l_q        <= sr_l_d;
            sr_r_q        <= sr_r_d;
            cnt_q         <= cnt_d;
            dacdat_q      <= dacdat_d;
            underflow_q   <= underflow_d;
        end
    end

    assign write_ready = write_ready_q;
    assign dacdat      = dacdat_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Randomized bench for audio_dac_serializer: a queue model of the FIFO plus a per-bit-slot
// rule predicts dacdat at every bit-clock rising edge (where a codec samples it).
module tb_audio_dac_serializer;

    localparam int W     = 24;
    localparam int DEPTH = 4;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] left_in = '0;
    logic [W-1:0] right_in = '0;
    logic         write = 1'b0;
    logic         write_ready;
    logic         bclk = 1'b1;
    logic         daclrck = 1'b1;
    logic         dacdat;
    logic         underflow;

    audio_dac_serializer #(.W(W), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .left_in     (left_in),
        .right_in    (right_in),
        .write       (write),
        .write_ready (write_ready),
        .bclk        (bclk),
        .daclrck     (daclrck),
        .dacdat      (dacdat),
        .underflow   (underflow)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int uf_cnt = 0;

    logic [2*W-1:0] q[$];
    logic           exp_bit = 1'b0;
    logic           chk_en = 1'b0;
    logic           held = 1'b0;
    logic [31:0]    obs = '0;
    logic [31:0]    last_l, last_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit slot j (1-based bit-clock period after a channel edge): slot 1 is the I2S delay bit,
    // slots 2..W+1 carry the sample MSB first, later slots are padding.
    function automatic logic slot_bit(input logic [W-1:0] s, input int j);
        if (j >= 2 && j <= W + 1) return s[W + 1 - j];
        return 1'b0;
    endfunction

    always @(posedge bclk) begin
        if (chk_en) begin
            check("dacdat_slot", 32'(dacdat), 32'(exp_bit));
            obs  = {obs[30:0], dacdat};
            held = dacdat;
        end
    end

    // Data must stay put through the whole high phase of the bit clock.
    always @(negedge bclk) begin
        if (chk_en) check("dacdat_hold", 32'(dacdat), 32'(held));
    end

    always @(negedge clock) begin
        if (underflow) uf_cnt++;
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
        check("write_ready", 32'(write_ready), 32'(q.size() < DEPTH));
        left_in  = l;
        right_in = r;
        write    = 1'b1;
        @(negedge clock);
        write = 1'b0;
        if (q.size() < DEPTH) q.push_back({l, r});
    endtask

    task automatic run_frame(input int n, input bit push_rand, input bit push_at_load,
                             input int reset_at);
        logic [2*W-1:0] pair;
        logic [W-1:0]   smp;
        bit             was_empty, was_full;
        int             uf0;
        uf0       = uf_cnt;
        was_empty = (q.size() == 0);
        was_full  = (q.size() == DEPTH);
        pair      = '0;
        if (!was_empty) pair = q.pop_front();
        for (int ch = 0; ch < 2; ch++) begin
            smp     = (ch == 0) ? pair[2*W-1:W] : pair[W-1:0];
            daclrck = (ch == 1);
            obs     = '0;
            if (ch == 0 && push_at_load) begin
                // Lands on the clock edge where the frame-start pop happens.
                wait_neg(3);
                left_in  = W'($urandom);
                right_in = W'($urandom);
                write    = 1'b1;
                wait_neg(1);
                write = 1'b0;
                if (!was_full) q.push_back({left_in, right_in});
                wait_neg(1);
                check("ready_after_load", 32'(write_ready), 32'(q.size() < DEPTH));
            end else begin
                wait_neg(5);
            end
            for (int j = 1; j <= n; j++) begin
                bclk = 1'b0;
                if (ch == 0 && j == reset_at) begin
                    wait_neg(3);
                    check("pre_reset_dacdat", 32'(dacdat), 32'(slot_bit(smp, j)));
                    chk_en  = 1'b0;
                    reset_n = 1'b0;
                    #1;
                    check("reset_dacdat", 32'(dacdat), 32'd0);
                    check("reset_ready", 32'(write_ready), 32'd0);
                    check("reset_underflow", 32'(underflow), 32'd0);
                    q.delete();
                    return;
                end
                wait_neg(5);
                exp_bit = slot_bit(smp, j);
                bclk    = 1'b1;
                if (push_rand && j >= 3 && $urandom_range(0, 3) == 0) begin
                    push(W'($urandom), W'($urandom));
                    wait_neg(4);
                end else begin
                    wait_neg(5);
                end
            end
            if (ch == 0) last_l = obs;
            else last_r = obs;
        end
        check("underflow_count", 32'(uf_cnt - uf0), was_empty ? 32'd1 : 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ns[4];
        ns = '{16, 20, 27, 32};

        wait_neg(3);
        check("rst_ready", 32'(write_ready), 32'd0);
        check("rst_dacdat", 32'(dacdat), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        reset_n = 1'b1;
        #1;
        check("ready_at_release", 32'(write_ready), 32'd0);
        @(negedge clock);
        check("ready_first_cycle", 32'(write_ready), 32'd1);
        wait_neg(2);
        chk_en = 1'b1;

        // One known pair over a full 64-bclk frame.
        push(24'hA5A5A5, 24'h5A5A5A);
        run_frame(32, 1'b0, 1'b0, 0);
        check("pin_left", last_l, 32'h52D2_D280);
        check("pin_right", last_r, 32'h2D2D_2D00);

        // Fill with no frame activity; the fifth write bounces off.
        for (int i = 0; i < 4; i++) push(W'($urandom), W'($urandom));
        @(negedge clock);
        check("full_ready", 32'(write_ready), 32'd0);
        push(24'h111111, 24'h222222);
        for (int i = 0; i < 4; i++) run_frame(32, 1'b0, 1'b0, 0);

        // Empty FIFO: silent frames, one underflow each.
        for (int i = 0; i < 2; i++) run_frame(32, 1'b0, 1'b0, 0);

        // Short 32-bclk frame truncates each channel.
        push(24'h123456, 24'hFEDCBA);
        run_frame(16, 1'b0, 1'b0, 0);
        check("pin_short_left", last_l, 32'h0000_091A);
        check("pin_short_right", last_r, 32'h0000_7F6E);

        // Full FIFO with a write coinciding with the pop.
        for (int i = 0; i < 4; i++) push(W'($urandom), W'($urandom));
        run_frame(32, 1'b0, 1'b1, 0);
        for (int i = 0; i < 4; i++) run_frame(32, 1'b0, 1'b0, 0);

        // Randomized traffic with mixed frame lengths.
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < $urandom_range(0, 2); k++) push(W'($urandom), W'($urandom));
            run_frame(ns[$urandom_range(0, 3)], 1'b1, 1'b0, 0);
        end

        // Reset in the middle of a left channel with three pairs queued.
        while (q.size() > 0) run_frame(32, 1'b0, 1'b0, 0);
        push(24'hFFFFFF, 24'hFFFFFF);
        push(W'($urandom), W'($urandom));
        push(W'($urandom), W'($urandom));
        run_frame(32, 1'b0, 1'b0, 6);
        @(negedge clock);
        bclk    = 1'b1;
        daclrck = 1'b1;
        wait_neg(3);
        reset_n = 1'b1;
        @(negedge clock);
        check("ready_after_reset", 32'(write_ready), 32'd1);
        held   = 1'b0;
        chk_en = 1'b1;
        wait_neg(3);
        run_frame(32, 1'b0, 1'b0, 0);
        push(24'h0F0F0F, 24'h800001);
        run_frame(32, 1'b0, 1'b0, 0);
        run_frame(32, 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
